// File: rtl/dsp_mul_signed_reg_with_accum_parametrized.sv
// ---------------------------------------------------------------------------
// dsp_mul_signed_reg_with_accum_parametrized
//
// Signed multiply-accumulate with registered operands and a registered
// accumulator, shaped to map onto a single DSP slice. Each clock the product
// of the previously registered operands is added to, or subtracted from, a
// running accumulator that wraps modulo 2^(A_WIDTH+B_WIDTH).
//
// Ports:
//   clk        - single clock, rising-edge active
//   reset      - synchronous, active-high; clears operands, mode and accumulator
//   subtract_i - accumulate mode (0 = add product, 1 = subtract product),
//                registered alongside the operands it applies to
//   A          - signed operand A, A_WIDTH bits
//   B          - signed operand B, B_WIDTH bits
//   P          - signed accumulator, A_WIDTH+B_WIDTH bits, straight from a flop
// ---------------------------------------------------------------------------
module dsp_mul_signed_reg_with_accum_parametrized #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              subtract_i,
  input  logic signed [A_WIDTH-1:0]         A,
  input  logic signed [B_WIDTH-1:0]         B,
  output logic signed [A_WIDTH+B_WIDTH-1:0] P
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  // Full-precision signed product. Both operands are sign-extended to the
  // result width first so the multiply never drops the upper bits.
  function automatic logic signed [P_W-1:0] full_product(
    input logic signed [A_WIDTH-1:0] a,
    input logic signed [B_WIDTH-1:0] b
  );
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    a_ext = a;
    b_ext = b;
    return a_ext * b_ext;
  endfunction

  // One accumulate step; the sum wraps naturally at P_W bits.
  function automatic logic signed [P_W-1:0] mac_step(
    input logic signed [P_W-1:0] acc,
    input logic signed [P_W-1:0] prod,
    input logic                  sub
  );
    return sub ? (acc - prod) : (acc + prod);
  endfunction

  logic signed [A_WIDTH-1:0] a_p1_q;
  logic signed [B_WIDTH-1:0] b_p1_q;
  logic                      sub_p1_q;
  logic signed [P_W-1:0]     prod_p1;
  logic signed [P_W-1:0]     acc_p2_d;
  logic signed [P_W-1:0]     acc_p2_q;

  // ---- stage 1: operand and mode registers --------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_p1_q   <= '0;
      b_p1_q   <= '0;
      sub_p1_q <= 1'b0;
    end else begin
      a_p1_q   <= A;
      b_p1_q   <= B;
      sub_p1_q <= subtract_i;
    end
  end

  always_comb begin
    prod_p1  = full_product(a_p1_q, b_p1_q);
    acc_p2_d = mac_step(acc_p2_q, prod_p1, sub_p1_q);
  end

  // ---- stage 2: accumulator register --------------------------------------
  // Reset also clears the accumulator, discarding any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p2_q <= '0;
    end else begin
      acc_p2_q <= acc_p2_d;
    end
  end

  assign P = acc_p2_q;

endmodule

// File: tb/tb_dsp_mul_signed_reg_with_accum_parametrized.sv
module tb_dsp_mul_signed_reg_with_accum_parametrized;

  localparam int AW = 32;
  localparam int BW = 32;

  logic                     clk;
  logic                     reset;
  logic                     subtract_i;
  logic signed [AW-1:0]     A;
  logic signed [BW-1:0]     B;
  logic signed [AW+BW-1:0]  P;

  int total;
  int bad;
  int idx;
  longint exp_q[$];

  dsp_mul_signed_reg_with_accum_parametrized #(
    .A_WIDTH(AW),
    .B_WIDTH(BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .subtract_i (subtract_i),
    .A          (A),
    .B          (B),
    .P          (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on the falling edge and queue the value P
  // must show right after the following rising edge.
  task automatic step(input logic r, input logic s, input longint a,
                      input longint b, input longint exp_p);
    @(negedge clk);
    reset      = r;
    subtract_i = s;
    A          = AW'(a);
    B          = BW'(b);
    exp_q.push_back(exp_p);
  endtask

  // Monitor: P is registered, so it is valid one step after every rising edge.
  initial begin
    longint e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (P !== e) begin
          bad++;
          $display("FAIL P[%0d] got=%0d (0x%h) exp=%0d (0x%h)", idx, P, P, e, e);
        end
        idx++;
      end
    end
  end

  initial begin
    longint e;
    longint pa, pb;
    total = 0;
    bad   = 0;
    idx   = 0;
    reset = 1'b1;
    subtract_i = 1'b0;
    A = '0;
    B = '0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Directed add: 5*2 reaches P two edges after it is sampled
    step(0, 0, 5, 2, 0);
    step(0, 0, 5, 2, 10);
    step(0, 0, 5, 2, 20);

    // Add run with A=-7, B=3 after a fresh reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    e = 0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) e = e + (-7 * 3);
      step(0, 0, -7, 3, e);
    end
    // After 31 contributions: -651
    step(0, 0, 0, 0, -672);

    // Mid-run reset with subtract set
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 5, 2, 0);
    step(0, 1, 5, 2, -10);
    step(0, 1, 5, 2, -20);

    // Subtract run; the first edge still retires the pending 5*2
    e  = -20;
    pa = 5;
    pb = 2;
    for (int k = 0; k < 32; k++) begin
      e  = e - pa * pb;
      pa = 123456789;
      pb = -98765;
      step(0, 1, 123456789, -98765, e);
    end

    // Corner: (-2^31)*(-2^31) = 2^62 per cycle, wrapping at 2^64
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, -64'sd2147483648, -64'sd2147483648, 0);
    step(0, 0, -64'sd2147483648, -64'sd2147483648, 64'h4000_0000_0000_0000);
    step(0, 0, -64'sd2147483648, -64'sd2147483648, 64'h8000_0000_0000_0000);
    step(0, 0, -64'sd2147483648, -64'sd2147483648, 64'hC000_0000_0000_0000);
    step(0, 0, 0, 0, 0);

    // Mode toggled per cycle: each sign follows its own operands
    step(1, 0, 0, 0, 0);
    step(0, 0, 3, 4, 0);
    step(0, 1, 2, 5, 12);
    step(0, 0, -1, 7, 2);
    step(0, 1, 6, -3, -5);
    step(0, 1, -64'sd2147483648, 64'sd2147483647, 13);
    step(0, 0, 0, 0, 64'h3FFF_FFFF_8000_000D);

    // Drain the scoreboard, bounded
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
